fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end sitting directly upstream of the core's decode stage.
- Owns the fetch PC and issues word-aligned read requests to instruction memory through a req/gnt interface; responses may arrive with variable latency but always in order.
- Each returned word is tagged with its PC and held in a small FIFO for decode, using a valid/ready handshake.
- On a branch/jump redirect it flushes the FIFO and discards responses still in flight.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum outstanding requests; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  request valid.
- imem_addr  out  32  request byte address, always word-aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  one-cycle pulse, read data valid.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse to flush and restart.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode consumes the head.
- out_instr  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of out_instr.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - fetch_pc = rsp_pc = RESET_PC.
  - FIFO count = 0; inflight = 0; drop = 0.
  - imem_req = 0, out_valid = 0, out_instr = 0, out_pc = 0.
  - Reset mid-operation aborts everything; responses after reset for pre-reset requests are ignored, because inflight = 0.
- State held:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next live response.
  - count: FIFO occupancy, 0..DEPTH.
  - inflight: all outstanding requests, 0..DEPTH.
  - drop: stale outstanding responses still to discard.
- Issue rule:
  - imem_req = !rst && !redirect_valid && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - Request is accepted when imem_req && imem_gnt. Then fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and inflight increments.
  - imem_req stays high while the condition holds, and is not registered. imem_addr is stable while the request waits for gnt.
- Response rule, when imem_rsp_valid:
  - inflight decrements.
  - If drop > 0: drop decrements and the data is discarded.
  - Otherwise: push {rsp_pc, imem_rsp_data} into the FIFO; rsp_pc += 4.
  - A response with inflight = 0 is a protocol violation: it is ignored and no counters change.
- Credit check guarantees a live push never meets a full FIFO.
- Output side:
  - out_valid = (count != 0); out_instr and out_pc are taken from the FIFO head.
  - Pop when out_valid && out_ready; push and pop in the same cycle are both honoured.
  - Head fields are stable while out_valid && !out_ready.
- Redirect (redirect_valid = 1):
  - Highest priority after rst.
  - In the same edge: FIFO cleared (count = 0), fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - drop = inflight; inflight decrements if a response also arrives this cycle, and that response is discarded.
  - A pop in the redirect cycle is accepted by decode but has no further effect.
  - No request is issued in the redirect cycle; issuing resumes the next cycle at the new PC.
- Latency:
  - Request accepted at edge t, with the response pulse in the cycle after acceptance: word pushed at edge t+1, out_valid high from t+1.
  - First request after reset is at the first cycle with rst low.
- Throughput: one instruction per cycle when memory grants and responds every cycle and out_ready is held high.

Test Plan:
- Reset release, 1-cycle memory, out_ready = 1: pairs appear as 0x000/I0, 0x004/I1, 0x008/I2, one per cycle; imem_req never drops.
- out_ready = 0 with DEPTH = 4: exactly 4 requests are accepted (0x0..0xC) and then imem_req = 0. Set ready = 1: 4 pops in order, then fetch resumes at 0x10.
- imem_gnt low for 3 cycles: imem_addr is held at 0x8, no PC advance; the order of outputs is preserved.
- 3-cycle memory latency, redirect to 0x103 with 2 requests in flight: both stale responses are dropped. Next output is pc = 0x100, then 0x104; no stale PC is ever presented.
- Redirect in the same cycle as a response and a pop: FIFO empty next cycle, out_valid = 0. First new request is at the redirect PC one cycle later.
- rst asserted mid-stream with 2 in flight: outputs clear next edge. Late responses are ignored, and fetch restarts at RESET_PC = 0x0.
- Wrap: RESET_PC = 0xFFFFFFF8 gives output PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned imem reads under a credit limit,
// tags in-order responses with their PC and queues them for decode.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [31:0]     fetch_pc;
  logic [31:0]     rsp_pc;

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic [31:0]     redirect_aligned;
  logic            unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credits cover both queued words and words still in flight, so a live
  // response can never arrive at a full FIFO.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign imem_req    = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc;
  assign req_fire    = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok = imem_rsp_valid && (inflight != '0);
  assign push   = rsp_ok && (drop == '0) && !redirect_valid;
  assign pop    = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
  assign out_pc    = out_valid ? mem[rd_ptr].pc    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding becomes stale; a response landing now is one of them.
      fetch_pc <= redirect_aligned;
      rsp_pc   <= redirect_aligned;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= inflight - CW'(rsp_ok);
      drop     <= inflight - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (drop != '0)) drop <= drop - 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // and the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a pin-level vector table followed by
// memory-model driven sequences for stalls, redirects, reset and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_gnt;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_instr, out_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  // Same handshake timing as u_dut, so it can share the memory model.
  fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(w_valid), .out_ready(out_ready),
    .out_instr(w_instr), .out_pc(w_pc)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rsp_v;
    logic [31:0] rsp_d;
    bit          redir;
    logic [31:0] redir_pc;
    bit          ready;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    bit          chk_head;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  int          cyc;
  int          lat;
  bit          gnt_en;
  int          req_low;
  logic        s_req, s_valid;
  logic [31:0] s_addr;
  pend_t       q[$];
  pair_t       pops[$];
  logic [31:0] wpops[$];
  logic [31:0] reqs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // One clock of the in-order memory model: answer the oldest due request,
  // sample the DUT mid-cycle, log accepted requests and consumed words.
  task automatic step();
    imem_gnt       = gnt_en;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (q.size() != 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(q[0].addr);
      void'(q.pop_front());
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    if (!imem_req && !rst) req_low++;
    if (imem_req && imem_gnt) begin
      reqs.push_back(imem_addr);
      q.push_back('{imem_addr, cyc + lat});
    end
    if (out_valid && out_ready) pops.push_back('{out_pc, out_instr});
    if (w_valid && out_ready) wpops.push_back(w_pc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    q.delete();
    step();
    rst = 1'b0;
    pops.delete();
    wpops.delete();
    reqs.delete();
    req_low = 0;
  endtask

  task automatic check_pop(input string name, input int idx, input logic [31:0] pc,
                           input logic [31:0] instr);
    if (idx < pops.size()) begin
      check({name, ".pc"}, pops[idx].pc, pc);
      check({name, ".instr"}, pops[idx].instr, instr);
    end else begin
      check({name, ".count"}, pops.size(), idx + 1);
    end
  endtask

  task automatic check_req(input string name, input int idx, input logic [31:0] addr);
    if (idx < reqs.size()) check(name, reqs[idx], addr);
    else check({name, ".count"}, reqs.size(), idx + 1);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1,0,0,32'h0,        0,32'h0,   0, 0,32'h000,0,1,32'h00,32'h0};
    vecs[1]  = '{0,0,0,32'h0,        0,32'h0,   1, 1,32'h000,0,0,32'h00,32'h0};
    vecs[2]  = '{0,1,0,32'h0,        0,32'h0,   1, 1,32'h000,0,0,32'h00,32'h0};
    vecs[3]  = '{0,1,1,32'hAAAA_0000,0,32'h0,   1, 1,32'h004,0,0,32'h00,32'h0};
    vecs[4]  = '{0,0,1,32'hAAAA_0004,0,32'h0,   0, 1,32'h008,1,1,32'h00,32'hAAAA_0000};
    vecs[5]  = '{0,0,0,32'h0,        0,32'h0,   0, 1,32'h008,1,1,32'h00,32'hAAAA_0000};
    vecs[6]  = '{0,0,0,32'h0,        0,32'h0,   1, 1,32'h008,1,1,32'h00,32'hAAAA_0000};
    vecs[7]  = '{0,0,0,32'h0,        0,32'h0,   1, 1,32'h008,1,1,32'h04,32'hAAAA_0004};
    vecs[8]  = '{0,1,0,32'h0,        1,32'h203, 1, 0,32'h008,0,0,32'h00,32'h0};
    vecs[9]  = '{0,1,0,32'h0,        0,32'h0,   1, 1,32'h200,0,0,32'h00,32'h0};
    vecs[10] = '{0,1,1,32'hDEAD_BEEF,1,32'h40,  1, 0,32'h204,0,0,32'h00,32'h0};
    vecs[11] = '{0,1,0,32'h0,        0,32'h0,   1, 1,32'h040,0,0,32'h00,32'h0};
    vecs[12] = '{0,0,1,32'hBBBB_0040,0,32'h0,   1, 1,32'h044,0,0,32'h00,32'h0};
    vecs[13] = '{0,0,0,32'h0,        0,32'h0,   1, 1,32'h044,1,1,32'h40,32'hBBBB_0040};
    vecs[14] = '{1,0,0,32'h0,        0,32'h0,   0, 0,32'h044,0,0,32'h00,32'h0};
    vecs[15] = '{0,0,0,32'h0,        0,32'h0,   0, 1,32'h000,0,1,32'h00,32'h0};

    rst = 1'b1; imem_gnt = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    cyc = 0; lat = 1; gnt_en = 1'b0; req_low = 0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      imem_gnt       = vecs[i].gnt;
      imem_rsp_valid = vecs[i].rsp_v;
      imem_rsp_data  = vecs[i].rsp_d;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      out_ready      = vecs[i].ready;
      #1;
      check($sformatf("v%0d.req", i), imem_req, vecs[i].e_req);
      check($sformatf("v%0d.addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d.valid", i), out_valid, vecs[i].e_valid);
      if (vecs[i].chk_head) begin
        check($sformatf("v%0d.pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("v%0d.instr", i), out_instr, vecs[i].e_instr);
      end
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;

    // Back-to-back throughput with a 1-cycle memory; also the wrapping instance.
    do_reset();
    lat = 1; gnt_en = 1'b1; out_ready = 1'b1;
    repeat (8) step();
    check("thru.pops", pops.size(), 6);
    check("thru.req_low", req_low, 0);
    check_pop("thru0", 0, 32'h0, instr_of(32'h0));
    check_pop("thru1", 1, 32'h4, instr_of(32'h4));
    check_pop("thru2", 2, 32'h8, instr_of(32'h8));
    check("wrap.n", wpops.size() >= 3, 1'b1);
    if (wpops.size() >= 3) begin
      check("wrap0", wpops[0], 32'hFFFF_FFF8);
      check("wrap1", wpops[1], 32'hFFFF_FFFC);
      check("wrap2", wpops[2], 32'h0000_0000);
    end

    // Decode stalled: the credit limit caps requests at DEPTH.
    do_reset();
    out_ready = 1'b0;
    repeat (8) step();
    check("stall.reqs", reqs.size(), 4);
    check_req("stall.req3", 3, 32'hC);
    check("stall.req_off", s_req, 1'b0);
    out_ready = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 4; i++)
      check_pop($sformatf("stall.pop%0d", i), i, 32'(i * 4), instr_of(32'(i * 4)));
    check_req("stall.resume", 4, 32'h10);

    // Grant withheld: address holds, order preserved.
    do_reset();
    repeat (2) step();
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("gnt.addr%0d", i), s_addr, 32'h8);
      check($sformatf("gnt.req%0d", i), s_req, 1'b1);
    end
    gnt_en = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++)
      check_pop($sformatf("gnt.pop%0d", i), i, 32'(i * 4), instr_of(32'(i * 4)));

    // 3-cycle memory, redirect with two stale responses in flight.
    do_reset();
    lat = 3;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    check("redir3.req", s_req, 1'b0);
    redirect_valid = 1'b0;
    repeat (12) step();
    check_pop("redir3.pop0", 0, 32'h100, instr_of(32'h100));
    check_pop("redir3.pop1", 1, 32'h104, instr_of(32'h104));

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat = 1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    check("rdx.req", s_req, 1'b0);
    check("rdx.valid", s_valid, 1'b1);
    redirect_valid = 1'b0;
    step();
    check("rdx.valid_next", s_valid, 1'b0);
    check("rdx.req_next", s_req, 1'b1);
    check("rdx.addr_next", s_addr, 32'h300);
    repeat (4) step();
    check_pop("rdx.pop1", 1, 32'h4, instr_of(32'h4));
    check_pop("rdx.pop2", 2, 32'h300, instr_of(32'h300));

    // Reset mid-stream with two requests outstanding; late responses ignored.
    do_reset();
    lat = 3;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0; gnt_en = 1'b0;
    step();
    check("rst.valid0", s_valid, 1'b0);
    check("rst.addr", s_addr, 32'h0);
    check("rst.req", s_req, 1'b1);
    step();
    check("rst.valid1", s_valid, 1'b0);
    step();
    check("rst.valid2", s_valid, 1'b0);
    pops.delete();
    gnt_en = 1'b1;
    repeat (12) step();
    check_pop("rst.pop0", 0, 32'h0, instr_of(32'h0));
    check_pop("rst.pop1", 1, 32'h4, instr_of(32'h4));
    check_pop("rst.pop2", 2, 32'h8, instr_of(32'h8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
